// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, widths and BCD helper for the stopwatch counter
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } sw_state_e;

    localparam int DIGIT_W = 4;
    localparam int MS_W    = 12;
    localparam int SEC_W   = 8;
    localparam int MIN_W   = 8;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX_DEC = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_SEX = 4'd5;

    // Value a bcd_digit will hold after the coming edge, from its visible state.
    function automatic logic [DIGIT_W-1:0] bcd_next(
        input logic [DIGIT_W-1:0] d,
        input logic               clr,
        input logic               inc,
        input logic               carry
    );
        if (clr) begin
            return '0;
        end else if (carry) begin
            return '0;
        end else if (inc) begin
            return d + 4'd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// rtl/stopwatch_bcd_digit.sv - one BCD digit counting 0..MAX with carry out
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_DEC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit value: clear beats increment, MAX rolls back to zero.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - BCD stopwatch with run/halt FSM; lap freeze under STOPWATCH_LAP_EN
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             msclock,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    output logic [MS_W-1:0]  ms_bcd,
    output logic [SEC_W-1:0] sec_bcd,
    output logic [MIN_W-1:0] min_bcd,
    output logic             running,
    output logic             overflow,
    output logic             lap_active
);

    localparam logic [MIN_W-1:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

    sw_state_e state_q, state_d;
    logic      running_q, running_d;
    logic      overflow_q, overflow_d;

    logic [DIGIT_W-1:0] ms_u, ms_t, ms_h, sec_u, sec_t, min_u, min_t;
    logic c_ms_u, c_ms_t, c_ms_h, c_sec_u, c_sec_t, c_min_u, c_min_t;
    logic tick;
    logic min_wrap;
    logic min_clr;

    logic [MS_W-1:0]  live_ms;
    logic [SEC_W-1:0] live_sec;
    logic [MIN_W-1:0] live_min;

    // A tick only counts in RUN; clear in the same cycle wins.
    assign tick     = (state_q == ST_RUN) && msclock && !clear;
    // Minutes wrap at MIN_MAX; the tens carry at 99 is the hard ceiling.
    assign min_wrap = (c_sec_t && (live_min == MIN_MAX_BCD)) || c_min_t;
    assign min_clr  = clear || min_wrap;

    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_ms_u  (.clk(clk), .rst_n(rst_n), .clr(clear),   .inc(tick),    .digit(ms_u),  .carry(c_ms_u));
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_ms_t  (.clk(clk), .rst_n(rst_n), .clr(clear),   .inc(c_ms_u),  .digit(ms_t),  .carry(c_ms_t));
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_ms_h  (.clk(clk), .rst_n(rst_n), .clr(clear),   .inc(c_ms_t),  .digit(ms_h),  .carry(c_ms_h));
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_sec_u (.clk(clk), .rst_n(rst_n), .clr(clear),   .inc(c_ms_h),  .digit(sec_u), .carry(c_sec_u));
    bcd_digit #(.MAX(DIGIT_MAX_SEX)) u_sec_t (.clk(clk), .rst_n(rst_n), .clr(clear),   .inc(c_sec_u), .digit(sec_t), .carry(c_sec_t));
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_min_u (.clk(clk), .rst_n(rst_n), .clr(min_clr), .inc(c_sec_t), .digit(min_u), .carry(c_min_u));
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_min_t (.clk(clk), .rst_n(rst_n), .clr(min_clr), .inc(c_min_u), .digit(min_t), .carry(c_min_t));

    assign live_ms  = {ms_h, ms_t, ms_u};
    assign live_sec = {sec_t, sec_u};
    assign live_min = {min_t, min_u};

    // Run/halt next state: clear > stop > start; overflow is sticky until clear.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_HALT;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
        end
        running_d  = (state_d == ST_RUN);
        overflow_d = clear ? 1'b0 : (overflow_q || min_wrap);
    end

    // FSM state and its registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
    logic             lap_active_q, lap_active_d;
    logic [MS_W-1:0]  lap_ms_q, lap_ms_d;
    logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
    logic [MIN_W-1:0] lap_min_q, lap_min_d;

    // Capture the post-edge live value on a lap strobe, release on the next one.
    always_comb begin
        lap_active_d = lap_active_q;
        lap_ms_d     = lap_ms_q;
        lap_sec_d    = lap_sec_q;
        lap_min_d    = lap_min_q;
        if (clear) begin
            lap_active_d = 1'b0;
        end else if (lap) begin
            lap_active_d = !lap_active_q;
            if (!lap_active_q) begin
                lap_ms_d  = {bcd_next(ms_h, clear, c_ms_t, c_ms_h),
                             bcd_next(ms_t, clear, c_ms_u, c_ms_t),
                             bcd_next(ms_u, clear, tick,   c_ms_u)};
                lap_sec_d = {bcd_next(sec_t, clear, c_sec_u, c_sec_t),
                             bcd_next(sec_u, clear, c_ms_h,  c_sec_u)};
                lap_min_d = {bcd_next(min_t, min_clr, c_min_u, c_min_t),
                             bcd_next(min_u, min_clr, c_sec_t, c_min_u)};
            end
        end
    end

    // Lap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_active_q <= 1'b0;
            lap_ms_q     <= '0;
            lap_sec_q    <= '0;
            lap_min_q    <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            lap_ms_q     <= lap_ms_d;
            lap_sec_q    <= lap_sec_d;
            lap_min_q    <= lap_min_d;
        end
    end

    assign lap_active = lap_active_q;
    assign ms_bcd     = lap_active_q ? lap_ms_q  : live_ms;
    assign sec_bcd    = lap_active_q ? lap_sec_q : live_sec;
    assign min_bcd    = lap_active_q ? lap_min_q : live_min;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign lap_active = 1'b0;
    assign ms_bcd     = live_ms;
    assign sec_bcd    = live_sec;
    assign min_bcd    = live_min;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;

    logic        clk;
    logic        rst_n;
    logic        msclock;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic [11:0] ms_bcd;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic        running;
    logic        overflow;
    logic        lap_active;

    int n_checks;
    int n_fail;

    stopwatch_counter #(.MIN_MAX(59)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .msclock    (msclock),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .lap        (lap),
        .ms_bcd     (ms_bcd),
        .sec_bcd    (sec_bcd),
        .min_bcd    (min_bcd),
        .running    (running),
        .overflow   (overflow),
        .lap_active (lap_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        start;
        logic        stop;
        logic        clear;
        logic        tick;
        logic [11:0] ms;
        logic [7:0]  sec;
        logic [7:0]  min;
        logic        running;
        logic        overflow;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_time(input string name, input logic [7:0] mn, input logic [7:0] sc, input logic [11:0] ms);
        check({name, ".min"}, {24'd0, min_bcd}, {24'd0, mn});
        check({name, ".sec"}, {24'd0, sec_bcd}, {24'd0, sc});
        check({name, ".ms"},  {20'd0, ms_bcd},  {20'd0, ms});
    endtask

    // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
    task automatic step(input logic s_start, input logic s_stop, input logic s_clear,
                        input logic s_tick, input logic s_lap);
        @(negedge clk);
        start   = s_start;
        stop    = s_stop;
        clear   = s_clear;
        msclock = s_tick;
        lap     = s_lap;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        msclock  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        lap      = 1'b0;

        //                 start stop clear tick  ms      sec    min    run ovf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h002, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h003, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h004, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h004, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h004, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 12'h004, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h004, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h006, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h007, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0};

        // Reset held while msclock free-runs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            msclock = ~msclock;
        end
        #1;
        check_time("reset", 8'h00, 8'h00, 12'h000);
        check("reset.running",    {31'd0, running},    32'd0);
        check("reset.overflow",   {31'd0, overflow},   32'd0);
        check("reset.lap_active", {31'd0, lap_active}, 32'd0);
        @(negedge clk);
        msclock = 1'b0;
        rst_n   = 1'b1;

        // Table of single-cycle FSM and tick interactions from IDLE.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].tick, 1'b0);
            check($sformatf("vec%0d", i), {20'd0, ms_bcd}, {20'd0, vecs[i].ms});
            check($sformatf("vec%0d.sec", i), {24'd0, sec_bcd}, {24'd0, vecs[i].sec});
            check($sformatf("vec%0d.min", i), {24'd0, min_bcd}, {24'd0, vecs[i].min});
            check($sformatf("vec%0d.running", i), {31'd0, running}, {31'd0, vecs[i].running});
            check($sformatf("vec%0d.overflow", i), {31'd0, overflow}, {31'd0, vecs[i].overflow});
        end

        // 1234 ticks ripple into seconds.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1234);
        check_time("run1234", 8'h00, 8'h01, 12'h234);
        check("run1234.running", {31'd0, running}, 32'd1);

        // Stop with a coincident tick still counts it, then holds.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(499);
        check_time("pre_stop", 8'h00, 8'h00, 12'h499);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_time("stop_tick", 8'h00, 8'h00, 12'h500);
        check("stop_tick.running", {31'd0, running}, 32'd0);
        ticks(10);
        check_time("halted", 8'h00, 8'h00, 12'h500);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_time("resume", 8'h00, 8'h00, 12'h501);

        // Preload 59:59.999 and wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        force dut.u_ms_u.digit_q  = 4'd9;
        force dut.u_ms_t.digit_q  = 4'd9;
        force dut.u_ms_h.digit_q  = 4'd9;
        force dut.u_sec_u.digit_q = 4'd9;
        force dut.u_sec_t.digit_q = 4'd5;
        force dut.u_min_u.digit_q = 4'd9;
        force dut.u_min_t.digit_q = 4'd5;
        #1;
        release dut.u_ms_u.digit_q;
        release dut.u_ms_t.digit_q;
        release dut.u_ms_h.digit_q;
        release dut.u_sec_u.digit_q;
        release dut.u_sec_t.digit_q;
        release dut.u_min_u.digit_q;
        release dut.u_min_t.digit_q;
        check("preload.overflow", {31'd0, overflow}, 32'd0);
        ticks(1);
        check_time("wrap", 8'h00, 8'h00, 12'h000);
        check("wrap.overflow", {31'd0, overflow}, 32'd1);
        ticks(5);
        check_time("post_wrap", 8'h00, 8'h00, 12'h005);
        check("post_wrap.overflow", {31'd0, overflow}, 32'd1);
        check("post_wrap.running",  {31'd0, running},  32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_time("wrap_clear", 8'h00, 8'h00, 12'h000);
        check("wrap_clear.overflow", {31'd0, overflow}, 32'd0);
        check("wrap_clear.running",  {31'd0, running},  32'd0);

        // Lap strobe behaviour.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
        check_time("lap_freeze", 8'h00, 8'h00, 12'h100);
        check("lap_freeze.active", {31'd0, lap_active}, 32'd1);
        ticks(50);
        check_time("lap_frozen", 8'h00, 8'h00, 12'h100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_time("lap_release", 8'h00, 8'h00, 12'h150);
        check("lap_release.active", {31'd0, lap_active}, 32'd0);
`else
        check_time("lap_ignored", 8'h00, 8'h00, 12'h100);
        check("lap_ignored.active", {31'd0, lap_active}, 32'd0);
        ticks(50);
        check_time("lap_live", 8'h00, 8'h00, 12'h150);
        check("lap_live.active", {31'd0, lap_active}, 32'd0);
`endif

        // Asynchronous reset mid-count.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2345);
        check_time("pre_reset", 8'h00, 8'h02, 12'h345);
        #2;
        rst_n = 1'b0;
        #1;
        check_time("async_reset", 8'h00, 8'h00, 12'h000);
        check("async_reset.running", {31'd0, running}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(5);
        check_time("post_reset_idle", 8'h00, 8'h00, 12'h000);
        check("post_reset_idle.running", {31'd0, running}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_time("post_reset_run", 8'h00, 8'h00, 12'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
